// File: rtl/vpu_pkg.sv
// Shared types and defaults for the vector-unit FP add/sub scheduler.
//   OPERAND_WIDTH  : FP32 operand/result width
//   FP_ADD_LATENCY : cycle latency configured on floating_point_add_sub
//   FP_ADD_NUM_REQ : default number of requesters sharing the adder
//   fp_op_t        : operation code driven on the IP operation channel
//   sched_state_t  : scheduler FSM states
package vpu_pkg;

    localparam int OPERAND_WIDTH  = 32;
    localparam int FP_ADD_LATENCY = 11;
    localparam int FP_ADD_NUM_REQ = 4;

    typedef enum logic {
        FP_ADD = 1'b0,
        FP_SUB = 1'b1
    } fp_op_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

endpackage

// File: rtl/floating_point_add_sub.sv
// Behavioural stand-in for the vendor floating_point_add_sub core (FP32,
// non-blocking AXI-stream, no aresetn, fixed latency). The vendor core has its
// latency fixed at generation time; LATENCY here must match that setting.
// Denormal inputs/results are flushed to zero, rounding is nearest-even.
//   aclk                        : clock
//   s_axis_a/b_tvalid, _tdata   : operands
//   s_axis_operation_tvalid/... : tdata[0] = 0 add, 1 subtract (a - b)
//   m_axis_result_tvalid/tdata  : result, LATENCY cycles after the inputs
//   m_axis_result_tuser         : {invalid_op, overflow, underflow}
module floating_point_add_sub #(
    parameter int LATENCY = 11
) (
    input  logic        aclk,
    input  logic        s_axis_a_tvalid,
    input  logic [31:0] s_axis_a_tdata,
    input  logic        s_axis_b_tvalid,
    input  logic [31:0] s_axis_b_tdata,
    input  logic        s_axis_operation_tvalid,
    input  logic [7:0]  s_axis_operation_tdata,
    output logic        m_axis_result_tvalid,
    output logic [31:0] m_axis_result_tdata,
    output logic [2:0]  m_axis_result_tuser
);

    // Returns {flags[2:0], result[31:0]}.
    function automatic logic [34:0] fp_addsub(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic        sub);
        logic        sa, sb, sr, swap;
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb;
        logic [26:0] mbig, msml, mask;
        logic [27:0] sum;
        logic [24:0] rnd;
        logic [31:0] res;
        logic [2:0]  flg;
        int          e, d;
        sa  = a[31];
        ea  = a[30:23];
        fa  = a[22:0];
        sb  = b[31] ^ sub;
        eb  = b[30:23];
        fb  = b[22:0];
        res = '0;
        flg = '0;
        if ((ea == 8'hFF && fa != '0) || (eb == 8'hFF && fb != '0)) begin
            res = 32'h7FC0_0000;
        end else if (ea == 8'hFF && eb == 8'hFF && sa != sb) begin
            res = 32'h7FC0_0000;
            flg = 3'b100;
        end else if (ea == 8'hFF) begin
            res = {sa, 8'hFF, 23'h0};
        end else if (eb == 8'hFF) begin
            res = {sb, 8'hFF, 23'h0};
        end else if (ea == 8'h00 && eb == 8'h00) begin
            res = {sa & sb, 31'h0};
        end else if (ea == 8'h00) begin
            res = {sb, eb, fb};
        end else if (eb == 8'h00) begin
            res = {sa, ea, fa};
        end else begin
            swap = {eb, fb} > {ea, fa};
            sr   = swap ? sb : sa;
            mbig = swap ? {1'b1, fb, 3'b000} : {1'b1, fa, 3'b000};
            msml = swap ? {1'b1, fa, 3'b000} : {1'b1, fb, 3'b000};
            e    = swap ? int'(eb) : int'(ea);
            d    = swap ? int'(eb) - int'(ea) : int'(ea) - int'(eb);
            // Alignment keeps everything shifted out as a sticky bit in bit 0.
            if (d > 26) begin
                msml = 27'd1;
            end else if (d > 0) begin
                mask = (27'd1 << d) - 27'd1;
                msml = (msml >> d) | {26'd0, |(msml & mask)};
            end
            sum = (sa != sb) ? {1'b0, mbig} - {1'b0, msml}
                             : {1'b0, mbig} + {1'b0, msml};
            if (sum == '0) begin
                res = 32'h0;
            end else begin
                if (sum[27]) begin
                    sum = {1'b0, sum[27:2], sum[1] | sum[0]};
                    e   = e + 1;
                end
                for (int i = 0; i < 26; i++) begin
                    if (!sum[26]) begin
                        sum = sum << 1;
                        e   = e - 1;
                    end
                end
                rnd = {1'b0, sum[26:3]} + 25'(sum[2] & (sum[1] | sum[0] | sum[3]));
                if (rnd[24]) begin
                    rnd = rnd >> 1;
                    e   = e + 1;
                end
                if (e >= 255) begin
                    res = {sr, 8'hFF, 23'h0};
                    flg = 3'b010;
                end else if (e <= 0) begin
                    res = {sr, 31'h0};
                    flg = 3'b001;
                end else begin
                    res = {sr, e[7:0], rnd[22:0]};
                end
            end
        end
        return {flg, res};
    endfunction

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [34:0]        pay_q [LATENCY];
    logic [34:0]        pay_d [LATENCY];
    logic               unused_op;

    assign unused_op = ^s_axis_operation_tdata[7:1];

    always_comb begin
        vld_d    = '0;
        pay_d    = pay_q;
        vld_d[0] = s_axis_a_tvalid & s_axis_b_tvalid & s_axis_operation_tvalid;
        pay_d[0] = fp_addsub(s_axis_a_tdata, s_axis_b_tdata, s_axis_operation_tdata[0]);
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            pay_d[i] = pay_q[i-1];
        end
    end

    always_ff @(posedge aclk) begin
        vld_q <= vld_d;
        pay_q <= pay_d;
    end

    assign m_axis_result_tvalid = vld_q[LATENCY-1];
    assign m_axis_result_tdata  = pay_q[LATENCY-1][31:0];
    assign m_axis_result_tuser  = pay_q[LATENCY-1][34:32];

endmodule

// File: rtl/vpu_tag_fifo.sv
// In-order FIFO holding the requester index of each operation in the adder.
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   push_i/_data_i: write one entry
//   pop_i         : remove the head entry; caller only pops when not empty
//   pop_data_o    : head entry
//   empty_o       : no entries held
// Depth is sized so it can never overflow at one issue per cycle.
module vpu_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push_i) begin
            mem_d[wr_q] = push_data_i;
            wr_d        = (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + AW'(1);
        end
        if (pop_i) begin
            rd_d = (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + AW'(1);
        end
        if (push_i && !pop_i) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!push_i && pop_i) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign pop_data_o = mem_q[rd_q];
    assign empty_o    = (cnt_q == '0);

endmodule

// File: rtl/vpu_fp_add_sched.sv
// Round-robin scheduler sharing one pipelined FP add/sub unit among NUM_REQ
// requesters. Results are routed back to the issuing requester by a tag FIFO.
//   clk, rst          : clock, synchronous active-high reset
//   en_i              : allow new issues (in-flight work always drains)
//   req_valid_i       : per-requester request
//   req_ready_o       : one-hot grant, issue = valid & ready
//   req_a_i, req_b_i  : packed FP32 operands, requester i in slice i
//   req_op_i          : per-requester op, 0 add, 1 subtract (a - b)
//   rsp_valid_o       : one-hot one-cycle result pulse to the owner
//   rsp_data_o        : shared result
//   rsp_flags_o       : {invalid_op, overflow, underflow}
//   idle_o            : running and nothing in flight
//   err_o             : sticky, adder produced a result with no tag queued
//
// state | meaning
// INIT  | quarantine after reset: no grants, adder results discarded,
//       | counter runs down from FP_LATENCY so abandoned work flushes out
// RUN   | normal round-robin issue and response routing
module vpu_fp_add_sched
    import vpu_pkg::*;
#(
    parameter int NUM_REQ    = FP_ADD_NUM_REQ,
    parameter int FP_LATENCY = FP_ADD_LATENCY
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             en_i,
    input  logic [NUM_REQ-1:0]               req_valid_i,
    output logic [NUM_REQ-1:0]               req_ready_o,
    input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*OPERAND_WIDTH-1:0] req_b_i,
    input  logic [NUM_REQ-1:0]               req_op_i,
    output logic [NUM_REQ-1:0]               rsp_valid_o,
    output logic [OPERAND_WIDTH-1:0]         rsp_data_o,
    output logic [2:0]                       rsp_flags_o,
    output logic                             idle_o,
    output logic                             err_o
);

    localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(FP_LATENCY + 1);

    sched_state_t             state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [TAG_W-1:0]         ptr_q, ptr_d;
    logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
    logic [OPERAND_WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [2:0]               rsp_flags_q, rsp_flags_d;
    logic                     err_q, err_d;

    logic [TAG_W-1:0]         cand, grant_idx, tag;
    logic                     found, issue, pop, fifo_empty;
    logic [OPERAND_WIDTH-1:0] a_sel, b_sel;
    fp_op_t                   op_sel;
    logic                     res_valid;
    logic [OPERAND_WIDTH-1:0] res_data;
    logic [2:0]               res_flags;

    // First valid requester at or after ptr, wrapping.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = TAG_W'((int'(ptr_q) + k) % NUM_REQ);
            if (!found && req_valid_i[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Gating with rst keeps anything issued in the reset cycle out of the adder.
    always_comb begin
        issue       = found & en_i & (state_q == RUN) & ~rst;
        req_ready_o = issue ? (NUM_REQ'(1) << grant_idx) : '0;
        a_sel       = req_a_i[int'(grant_idx)*OPERAND_WIDTH +: OPERAND_WIDTH];
        b_sel       = req_b_i[int'(grant_idx)*OPERAND_WIDTH +: OPERAND_WIDTH];
        op_sel      = fp_op_t'(req_op_i[grant_idx]);
        ptr_d       = ptr_q;
        if (issue) begin
            ptr_d = (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase
    end

    // Results arriving during INIT belong to abandoned work and are dropped.
    always_comb begin
        pop         = res_valid & (state_q == RUN) & ~fifo_empty;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        err_d       = err_q;
        if (pop) begin
            rsp_valid_d = NUM_REQ'(1) << tag;
            rsp_data_d  = res_data;
            rsp_flags_d = res_flags;
        end
        if (res_valid && (state_q == RUN) && fifo_empty) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            cnt_q       <= CNT_W'(FP_LATENCY);
            ptr_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
            err_q       <= err_d;
        end
    end

    vpu_tag_fifo #(
        .WIDTH (TAG_W),
        .DEPTH (FP_LATENCY + 1)
    ) u_tag_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (issue),
        .push_data_i (grant_idx),
        .pop_i       (pop),
        .pop_data_o  (tag),
        .empty_o     (fifo_empty)
    );

    floating_point_add_sub #(
        .LATENCY (FP_LATENCY)
    ) u_fp_add_sub (
        .aclk                    (clk),
        .s_axis_a_tvalid         (issue),
        .s_axis_a_tdata          (a_sel),
        .s_axis_b_tvalid         (issue),
        .s_axis_b_tdata          (b_sel),
        .s_axis_operation_tvalid (issue),
        .s_axis_operation_tdata  ({7'd0, op_sel}),
        .m_axis_result_tvalid    (res_valid),
        .m_axis_result_tdata     (res_data),
        .m_axis_result_tuser     (res_flags)
    );

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_flags_o = rsp_flags_q;
    assign err_o       = err_q;
    assign idle_o      = (state_q == RUN) & fifo_empty & ~(|rsp_valid_q);

endmodule

// File: tb/tb_vpu_fp_add_sched.sv
module tb_vpu_fp_add_sched;

    localparam int N = 4;
    localparam int L = 11;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           en_i;
    logic [N-1:0]   req_valid_i, req_ready_o, req_op_i, rsp_valid_o;
    logic [N*W-1:0] req_a_i, req_b_i;
    logic [W-1:0]   rsp_data_o;
    logic [2:0]     rsp_flags_o;
    logic           idle_o, err_o;

    vpu_fp_add_sched #(.NUM_REQ(N), .FP_LATENCY(L)) dut (
        .clk         (clk),
        .rst         (rst),
        .en_i        (en_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .req_op_i    (req_op_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_flags_o (rsp_flags_o),
        .idle_o      (idle_o),
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          idx;
        logic [31:0] data;
        logic [2:0]  flags;
        bit          nan;
        int          due;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] exp_data  [N];
    logic [2:0]  exp_flags [N];
    bit          exp_nan   [N];

    // Scheduler model: INIT quarantine length and round-robin pointer.
    bit run_m;
    int cnt_m;
    int ptr_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic op, input logic [31:0] d, input logic [2:0] f,
                           input bit nan);
        req_a_i[i*W +: W] = a;
        req_b_i[i*W +: W] = b;
        req_op_i[i]       = op;
        exp_data[i]       = d;
        exp_flags[i]      = f;
        exp_nan[i]        = nan;
    endtask

    task automatic load_mix();
        set_req(0, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 3'b000, 1'b0);
        set_req(1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 3'b000, 1'b0);
        set_req(2, 32'h4000_0000, 32'h4000_0000, 1'b0, 32'h4080_0000, 3'b000, 1'b0);
        set_req(3, 32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 3'b000, 1'b0);
    endtask

    // One clock: check the grant against the model, queue the expected response.
    task automatic step();
        logic [N-1:0] exp_rdy;
        int           g;
        @(negedge clk);
        exp_rdy = '0;
        g       = -1;
        if (!rst && run_m && en_i) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid_i[(ptr_m + k) % N]) g = (ptr_m + k) % N;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 32'(req_ready_o), 32'(exp_rdy));
        if (g >= 0) begin
            sb_q.push_back('{g, exp_data[g], exp_flags[g], exp_nan[g], cyc + L + 1});
            ptr_m = (g + 1) % N;
        end
        if (rst) sb_q.delete();
        @(posedge clk);
        if (rst) begin
            run_m = 1'b0;
            cnt_m = L;
            ptr_m = 0;
        end else if (!run_m) begin
            if (cnt_m == 0) run_m = 1'b1;
            else cnt_m--;
        end
        #1;
    endtask

    task automatic drain();
        req_valid_i = '0;
        repeat (L + 3) step();
    endtask

    task automatic wait_run();
        req_valid_i = '0;
        for (int i = 0; i < 40 && !run_m; i++) step();
        check("idle_after_init", 32'(idle_o), 32'd1);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                total++;
                bad++;
                $display("FAIL rsp_missing: got no response, expected requester %0d by cycle %0d",
                         sb_q[0].idx, sb_q[0].due);
                void'(sb_q.pop_front());
            end
            if (rsp_valid_o != '0) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rsp_unexpected: got rsp_valid %b expected none (cycle %0d)",
                             rsp_valid_o, cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("rsp_onehot", 32'(rsp_valid_o), 32'd1 << mon_e.idx);
                    check("rsp_cycle", cyc, mon_e.due);
                    if (mon_e.nan)
                        check("rsp_nan", 32'(rsp_data_o[30:23] == 8'hFF && rsp_data_o[22:0] != '0), 32'd1);
                    else
                        check("rsp_data", rsp_data_o, mon_e.data);
                    check("rsp_flags", 32'(rsp_flags_o), 32'(mon_e.flags));
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        en_i        = 1'b1;
        req_valid_i = '1;
        req_a_i     = '0;
        req_b_i     = '0;
        req_op_i    = '0;
        run_m       = 1'b0;
        cnt_m       = L;
        ptr_m       = 0;
        for (int i = 0; i < N; i++) set_req(i, 32'h0, 32'h0, 1'b0, 32'h0, 3'b000, 1'b0);

        // Reset values, then INIT holds off grants with every requester valid.
        repeat (3) step();
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_rsp_data", rsp_data_o, 32'd0);
        check("rst_rsp_flags", 32'(rsp_flags_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_idle", 32'(idle_o), 32'd0);
        check("rst_ready", 32'(req_ready_o), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 40 && !run_m; i++) step();
        req_valid_i = '0;
        check("idle_after_init", 32'(idle_o), 32'd1);

        // Single add from requester 1.
        set_req(1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 3'b000, 1'b0);
        req_valid_i = 4'b0010;
        step();
        drain();

        // Single subtract from requester 3.
        set_req(3, 32'h40A0_0000, 32'h4000_0000, 1'b1, 32'h4040_0000, 3'b000, 1'b0);
        req_valid_i = 4'b1000;
        step();
        drain();

        // All four requesters valid for 8 cycles.
        load_mix();
        req_valid_i = 4'b1111;
        repeat (8) step();
        drain();
        check("idle_after_burst", 32'(idle_o), 32'd1);

        // Enable low blocks grants while a result drains; raising it resumes at ptr.
        req_valid_i = 4'b0010;
        step();
        en_i        = 1'b0;
        req_valid_i = 4'b1111;
        repeat (4) step();
        en_i = 1'b1;
        step();
        drain();

        // Special values: inf - inf is invalid, max + max overflows.
        set_req(0, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 3'b100, 1'b1);
        set_req(2, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3'b010, 1'b0);
        req_valid_i = 4'b0101;
        repeat (2) step();
        drain();

        // Reset with four operations in flight: nothing may come back.
        load_mix();
        req_valid_i = 4'b1111;
        repeat (4) step();
        req_valid_i = '0;
        repeat (2) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < L + 2; i++) begin
            step();
            check("rst_quiet", 32'(rsp_valid_o), 32'd0);
        end
        wait_run();

        check("err_clear", 32'(err_o), 32'd0);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vpu_fp_add_sched.md
VPU_FP_ADD_SCHED -- requirements
Module: vpu_fp_add_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning the number of requesters sharing one FP add/sub unit (2..8).
REQ-002 SHALL have parameter FP_LATENCY, default 11, meaning the configured cycle latency of floating_point_add_sub.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 en_i  input  1  grant enable; low blocks new issues, in-flight operations drain.
REQ-007 req_valid_i  input  NUM_REQ  per-requester operation request.
REQ-008 req_ready_o  output  NUM_REQ  one-hot grant; issue = valid & ready.
REQ-009 req_a_i, req_b_i  input  NUM_REQ*OPERAND_WIDTH each  packed FP32 operands; requester i in slice i.
REQ-010 req_op_i  input  NUM_REQ  0 = add, 1 = subtract (a-b).
REQ-011 rsp_valid_o  output  NUM_REQ  one-hot, one-cycle result pulse to the owning requester.
REQ-012 rsp_data_o  output  OPERAND_WIDTH  result, shared by all requesters.
REQ-013 rsp_flags_o  output  3  IP tuser {invalid_op, overflow, underflow}.
REQ-014 idle_o  output  1  state RUN and no operations in flight.
REQ-015 err_o  output  1  sticky; IP result arrived with empty tag FIFO.

Function
REQ-016 FSM states: INIT and RUN; reset enters INIT, quarantine counter loaded with FP_LATENCY.
REQ-017 INIT: no grants, all IP results discarded, counter decrements each cycle; at 0 go to RUN.
REQ-018 RUN: when en_i=1 and any req_valid_i, grant exactly one requester round-robin, searching from pointer ptr.
REQ-019 ptr resets to 0; after a grant to i, ptr = (i+1) mod NUM_REQ; otherwise it holds.
REQ-020 req_ready_o is combinational from req_valid_i, ptr, en_i and state; at most one bit set; never set while req_valid_i of that bit is 0.
REQ-021 On issue, the granted operands and op drive the IP in the same cycle, tvalid=1; operation tdata 0x00 = add, 0x01 = sub.
REQ-022 On issue, the grant index is pushed into an in-order tag FIFO of depth FP_LATENCY+1.
REQ-023 On m_axis_result_tvalid in RUN, pop the tag; register rsp_valid_o[tag], rsp_data_o and rsp_flags_o. Total latency: issue cycle + FP_LATENCY + 1.
REQ-024 Responses have no backpressure; a requester must accept a pulse whenever it has an operation outstanding.
REQ-025 Back-to-back issues, including from the same requester, are permitted each cycle; throughput is 1 operation per cycle.
REQ-026 If an issue and a pop occur in the same cycle, FIFO occupancy is unchanged.
REQ-027 If result_tvalid arrives with the FIFO empty, drop the result and set err_o.
REQ-028 When en_i falls, grants stop next evaluation; outstanding results are still delivered.
REQ-029 idle_o = (state==RUN) & FIFO empty & no registered response pending.

Reset
REQ-030 rst SHALL clear: state→INIT, ptr=0, tag FIFO empty, rsp_valid_o=0, rsp_data_o=0, rsp_flags_o=0, err_o=0, idle_o=0, req_ready_o=0.
REQ-031 Reset mid-operation SHALL abandon in-flight operations; their IP results fall inside INIT quarantine and produce no rsp_valid_o.

Structure
REQ-032 VPU_PKG SHALL hold OPERAND_WIDTH, FP_ADD_LATENCY, FP_ADD_NUM_REQ, the fp_op_t enum (FP_ADD=0, FP_SUB=1) and the sched_state_t enum (INIT, RUN).
REQ-033 The block SHALL instantiate floating_point_add_sub once, with operand tvalids tied to the issue signal.
REQ-034 One sub-module, vpu_tag_fifo, SHALL implement the tag FIFO (parameterised width and depth).

Verification
REQ-035 Requester 1 issues a=0x3F800000, b=0x40000000, op=0 → rsp_valid_o=4'b0010 exactly FP_LATENCY+1 cycles later, rsp_data_o=0x40400000.
REQ-036 Requester 3 issues a=0x40A00000, b=0x40000000, op=1 → rsp_valid_o=4'b1000, rsp_data_o=0x40400000.
REQ-037 All four requesters held valid for 8 cycles → grant order 0,1,2,3,0,1,2,3; responses return in the same order, one per cycle.
REQ-038 rst asserted 3 cycles after 4 back-to-back issues → no rsp_valid_o for the following FP_LATENCY+2 cycles; idle_o=1 after INIT exits.
REQ-039 en_i=0 with all valid → req_ready_o=0 each cycle; raising en_i grants requester ptr first.
REQ-040 a=0x7F800000, b=0x7F800000, op=1 → rsp_data_o is a NaN with rsp_flags_o[2]=1.
